rgen_response_handshake_mux: RTL

Parametrised successor to the register-block response mux. It accepts one command at a time from the host-side bridge and waits for the selected register to signal ready, which allows variable register latency. It then returns read data and status over a valid/ready response channel with host backpressure. The block sits between the bus bridge and the register array and distinguishes decode errors from slave errors.

---
 rtl/rgen_response_handshake_mux_pkg.sv | 20 ++
 rtl/rgen_response_handshake_mux_if.sv | 30 +++
 rtl/rgen_response_handshake_mux_or_reducer.sv | 23 ++
 rtl/rgen_response_handshake_mux.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/rgen_response_handshake_mux_pkg.sv
// Shared types for the register-block response mux: status word, status codes, FSM states.
package rgen_rtl_pkg;

    typedef struct packed {
        logic exokay;
        logic decode_error;
        logic slave_error;
    } rgen_status_t;

    localparam rgen_status_t RGEN_STATUS_OKAY   = 3'b000;
    localparam rgen_status_t RGEN_STATUS_SLVERR = 3'b001;
    localparam rgen_status_t RGEN_STATUS_DECERR = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } rgen_response_state_e;

endpackage

// File: rtl/rgen_response_handshake_mux_if.sv
// Host command/response handshake plus register-array side signals of the response mux.
interface rgen_response_handshake_mux_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int TOTAL_REGISTERS = 1
);
    logic                       i_command_valid;
    logic                       i_command_write;
    logic                       o_command_ready;
    logic                       o_response_valid;
    logic                       i_response_ready;
    logic [DATA_WIDTH-1:0]      o_read_data;
    logic [2:0]                 o_status;
    logic [TOTAL_REGISTERS-1:0] i_register_select;
    logic [TOTAL_REGISTERS-1:0] i_register_ready;
    logic [TOTAL_REGISTERS-1:0] i_register_error;
    logic [DATA_WIDTH-1:0]      i_register_read_data [TOTAL_REGISTERS];

    // master: host bridge together with the register array it fronts
    modport master (
        output i_command_valid, i_command_write, i_response_ready,
        output i_register_select, i_register_ready, i_register_error, i_register_read_data,
        input  o_command_ready, o_response_valid, o_read_data, o_status
    );

    modport slave (
        input  i_command_valid, i_command_write, i_response_ready,
        input  i_register_select, i_register_ready, i_register_error, i_register_read_data,
        output o_command_ready, o_response_valid, o_read_data, o_status
    );
endinterface

// File: rtl/rgen_response_handshake_mux_or_reducer.sv
// AND-OR selection tree: ORs together every input word whose select bit is set.
// A single input degenerates to a plain gated path.
module rgen_or_reducer #(
    parameter int WIDTH = 1,
    parameter int N     = 1
) (
    input  logic [N-1:0]     i_sel,
    input  logic [WIDTH-1:0] i_dat [N],
    output logic [WIDTH-1:0] o_dat
);
    generate
        if (N == 1) begin : g_direct
            assign o_dat = i_sel[0] ? i_dat[0] : '0;
        end else begin : g_tree
            always_comb begin
                o_dat = '0;
                for (int j = 0; j < N; j++) begin
                    o_dat = o_dat | (i_dat[j] & {WIDTH{i_sel[j]}});
                end
            end
        end
    endgenerate
endmodule

// File: rtl/rgen_response_handshake_mux.sv
// One-at-a-time command to register array, waits for register ready, returns data/status
// over valid/ready. Optional wait timeout under `RGEN_RESPONSE_TIMEOUT_EN.
module rgen_response_handshake_mux
    import rgen_rtl_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int TOTAL_REGISTERS = 1,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    rgen_response_handshake_mux_if.slave  bus
);
    rgen_response_state_e  state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    rgen_status_t          status_q, status_d;
    logic                  resp_vld_q, resp_vld_d;
    logic                  cmd_rdy;

    logic [DATA_WIDTH-1:0] sel_dat;
    logic                  hit;
    logic                  err_hit;
    logic                  rdy_arr [TOTAL_REGISTERS];
    logic                  err_arr [TOTAL_REGISTERS];

    always_comb begin
        for (int j = 0; j < TOTAL_REGISTERS; j++) begin
            rdy_arr[j] = bus.i_register_ready[j];
            err_arr[j] = bus.i_register_ready[j] & bus.i_register_error[j];
        end
    end

    rgen_or_reducer #(.WIDTH(DATA_WIDTH), .N(TOTAL_REGISTERS)) u_dat_red (
        .i_sel (bus.i_register_select),
        .i_dat (bus.i_register_read_data),
        .o_dat (sel_dat)
    );

    rgen_or_reducer #(.WIDTH(1), .N(TOTAL_REGISTERS)) u_rdy_red (
        .i_sel (bus.i_register_select),
        .i_dat (rdy_arr),
        .o_dat (hit)
    );

    rgen_or_reducer #(.WIDTH(1), .N(TOTAL_REGISTERS)) u_err_red (
        .i_sel (bus.i_register_select),
        .i_dat (err_arr),
        .o_dat (err_hit)
    );

`ifdef RGEN_RESPONSE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo;
    assign tmo = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        status_d   = status_q;
        resp_vld_d = resp_vld_q;
        cmd_rdy    = 1'b0;
`ifdef RGEN_RESPONSE_TIMEOUT_EN
        cnt_d      = '0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.i_command_valid) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (bus.i_register_select == '0) begin
                    cmd_rdy    = 1'b1;
                    data_d     = '0;
                    status_d   = RGEN_STATUS_DECERR;
                    resp_vld_d = 1'b1;
                    state_d    = RESPOND;
                end else if (hit) begin
                    cmd_rdy    = 1'b1;
                    data_d     = bus.i_command_write ? '0 : sel_dat;
                    status_d   = '{exokay: 1'b0, decode_error: 1'b0, slave_error: err_hit};
                    resp_vld_d = 1'b1;
                    state_d    = RESPOND;
`ifdef RGEN_RESPONSE_TIMEOUT_EN
                end else if (tmo) begin
                    // register never answered: report as slave error
                    cmd_rdy    = 1'b1;
                    data_d     = '0;
                    status_d   = RGEN_STATUS_SLVERR;
                    resp_vld_d = 1'b1;
                    state_d    = RESPOND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            RESPOND: begin
                if (bus.i_response_ready) begin
                    data_d     = '0;
                    status_d   = RGEN_STATUS_OKAY;
                    resp_vld_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            data_q     <= '0;
            status_q   <= RGEN_STATUS_OKAY;
            resp_vld_q <= 1'b0;
`ifdef RGEN_RESPONSE_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            status_q   <= status_d;
            resp_vld_q <= resp_vld_d;
`ifdef RGEN_RESPONSE_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // command completion must be visible in the same ACCESS cycle the register answers
    assign bus.o_command_ready  = cmd_rdy;
    assign bus.o_response_valid = resp_vld_q;
    assign bus.o_read_data      = data_q;
    assign bus.o_status         = status_q;
endmodule
